rr_stream_arbiter: RTL and testbench

Parametrised N-channel stream arbiter that merges an array of valid/ready source interfaces into one registered output stream using round-robin priority. It is the next generation of our interface-array channel blocks: the per-channel interface array now carries a handshake and W-bit payload, and the block adds arbitration and a pipeline register. It sits between a bank of per-channel producers and a single shared consumer.

---
 rtl/rr_stream_arbiter_if.sv | 21 ++
 rtl/rr_stream_arbiter.sv | 99 +++++++++
 tb/tb_rr_stream_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_stream_arbiter_if.sv
// stream_intf: one valid/ready stream carrying a W-bit payload.
// source drives valid/data, sink drives ready.
interface stream_intf #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport source (
    output valid,
    output data,
    input  ready
  );

  modport sink (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: merges N valid/ready source streams into one
// registered output stream with round-robin priority.
module rr_stream_arbiter #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_intf.sink      src [N-1:0],
  stream_intf.source    dst,
  output logic [IW-1:0] grant_idx,
  output logic          busy
);

  logic [N-1:0]  vld;
  logic [W-1:0]  dat [N];
  logic [N-1:0]  gnt_oh;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic          load;

  logic          out_valid_q;
  logic          out_valid_d;
  logic [W-1:0]  out_data_q;
  logic [W-1:0]  out_data_d;
  logic [IW-1:0] out_idx_q;
  logic [IW-1:0] out_idx_d;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // (a + b) mod N for a < N and b <= N
  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] a,
    input int            b
  );
    int s;
    s = 32'(a) + b;
    if (s >= N) s = s - N;
    return s[IW-1:0];
  endfunction

  assign load = !out_valid_q || dst.ready;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign vld[i] = src[i].valid;
    assign dat[i] = src[i].data;
    assign src[i].ready = rst_n && load && gnt_oh[i];
  end

  always_comb begin
    gnt_oh  = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && vld[wrap_add(ptr_q, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_add(ptr_q, k);
      end
    end
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  // Empty cycle clears valid but keeps data/idx/ptr.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = dat[gnt_idx];
        out_idx_d  = gnt_idx;
        ptr_d      = wrap_add(gnt_idx, 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign dst.valid = out_valid_q;
  assign dst.data  = out_data_q;
  assign grant_idx = out_idx_q;
  assign busy      = out_valid_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: directed and random checks of a 4x8 arbiter
// plus a 1x1 instance used as a plain pipeline register.
module tb_rr_stream_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic cmp_on;
  logic sb_on;

  // ---- DUT A: N=4, W=8
  stream_intf #(.W(8)) sa [3:0] ();
  stream_intf #(.W(8)) da ();
  logic [3:0] svA;
  logic [3:0] rdyA;
  logic [3:0] rA_s;
  logic [7:0] sdA [4];
  logic       drA;
  logic [1:0] gA;
  logic       bA;

  for (genvar g = 0; g < 4; g++) begin : g_a
    assign sa[g].valid = svA[g];
    assign sa[g].data  = sdA[g];
    assign rdyA[g]     = sa[g].ready;
  end
  assign da.ready = drA;

  rr_stream_arbiter #(.N(4), .W(8)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (sa),
    .dst       (da),
    .grant_idx (gA),
    .busy      (bA)
  );

  // ---- DUT B: N=1, W=1
  stream_intf #(.W(1)) sb [0:0] ();
  stream_intf #(.W(1)) db ();
  logic svB;
  logic sdB;
  logic rdyB;
  logic rB_s;
  logic drB;
  logic gB;
  logic bB;

  assign sb[0].valid = svB;
  assign sb[0].data  = sdB;
  assign rdyB        = sb[0].ready;
  assign db.ready    = drB;

  rr_stream_arbiter #(.N(1), .W(1)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (sb),
    .dst       (db),
    .grant_idx (gB),
    .busy      (bB)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // first valid channel in order p, p+1, ... (mod 4), or -1
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // ---- reference model
  logic       mvA;
  logic [7:0] mdA;
  int         miA;
  int         mpA;
  logic       mvB;
  logic       mdB;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mvA <= 1'b0; mdA <= 8'h00; miA <= 0; mpA <= 0;
      mvB <= 1'b0; mdB <= 1'b0;
    end else begin
      if (!mvA || drA) begin
        if (pick(svA, mpA) >= 0) begin
          mvA <= 1'b1;
          mdA <= sdA[pick(svA, mpA)];
          miA <= pick(svA, mpA);
          mpA <= (pick(svA, mpA) + 1) % 4;
        end else begin
          mvA <= 1'b0;
        end
      end
      if (!mvB || drB) begin
        mvB <= svB;
        if (svB) mdB <= sdB;
      end
    end
  end

  function automatic logic [3:0] exp_rdyA();
    int g;
    g = pick(svA, mpA);
    if (rst_n && (!mvA || drA) && g >= 0) return 4'b0001 << g;
    return 4'b0000;
  endfunction

  always @(negedge clk) begin
    rA_s <= rdyA;
    rB_s <= rdyB;
    if (cmp_on) begin
      chk("a_valid", 32'(da.valid), 32'(mvA));
      chk("a_busy", 32'(bA), 32'(mvA));
      chk("a_idx", 32'(gA), miA);
      if (mvA) chk("a_data", 32'(da.data), 32'(mdA));
      chk("a_ready", 32'(rdyA), 32'(exp_rdyA()));
      chk("b_valid", 32'(db.valid), 32'(mvB));
      chk("b_busy", 32'(bB), 32'(mvB));
      chk("b_idx", 32'(gB), 0);
      if (mvB) chk("b_data", 32'(db.data), 32'(mdB));
      chk("b_ready", 32'(rdyB),
          32'(rst_n && (!mvB || drB) && svB));
    end
  end

  // ---- scoreboard for the N=1 register
  logic sbq [$];
  int   popped = 0;

  always @(posedge clk) begin
    if (sb_on) begin
      if (db.valid && drB) begin
        if (sbq.size() == 0) begin
          chk("b_sb_underflow", 32'(sbq.size()), 1);
        end else begin
          chk("b_sb_order", 32'(db.data), 32'(sbq.pop_front()));
          popped++;
        end
      end
      if (svB && rdyB) sbq.push_back(sdB);
    end
  end

  initial begin
    svA = 4'b0000; drA = 1'b0;
    for (int i = 0; i < 4; i++) sdA[i] = 8'h00;
    svB = 1'b0; sdB = 1'b0; drB = 1'b0;
    cmp_on = 1'b0; sb_on = 1'b0;
    #1 cmp_on = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(da.valid), 0);
    chk("rst_idx", 32'(gA), 0);
    chk("rst_ready", 32'(rdyA), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single channel 2
    svA = 4'b0100; sdA[2] = 8'hA5; drA = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(rdyA), 32'h4);
    @(posedge clk); #1;
    svA = 4'b0000;
    @(negedge clk);
    chk("single_valid", 32'(da.valid), 1);
    chk("single_data", 32'(da.data), 32'hA5);
    chk("single_idx", 32'(gA), 2);

    // ptr is now 3: channel 3 beats channel 0
    svA = 4'b1001; sdA[0] = 8'h50; sdA[3] = 8'h53;
    #1 chk("ptr3_ready", 32'(rdyA), 32'h8);
    @(negedge clk);
    chk("ptr3_data", 32'(da.data), 32'h53);
    chk("ptr3_idx", 32'(gA), 3);

    // reset while a word is held and sources are valid
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(da.valid), 0);
    chk("midrst_idx", 32'(gA), 0);
    chk("midrst_ready", 32'(rdyA), 0);
    chk("midrst_busy", 32'(bA), 0);
    @(posedge clk);
    @(posedge clk); #1;
    svA = 4'b0000;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_valid", 32'(da.valid), 0);
    end

    // fairness with all channels valid, including the 3 -> 0 wrap
    svA = 4'b1111;
    for (int i = 0; i < 4; i++) sdA[i] = 8'(8'h10 + i);
    drA = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("rr_data", 32'(da.data), 32'(8'h10 + (j % 4)));
      chk("rr_idx", 32'(gA), j % 4);
    end

    // back-pressure with 0x11 held
    drA = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_data", 32'(da.data), 32'h11);
      chk("bp_valid", 32'(da.valid), 1);
      chk("bp_ready", 32'(rdyA), 0);
    end
    drA = 1'b1;
    @(negedge clk);
    chk("bp_rel_data", 32'(da.data), 32'h12);
    chk("bp_rel_idx", 32'(gA), 2);
    @(negedge clk);
    chk("bp_next_data", 32'(da.data), 32'h13);

    // move ptr to 1, then skip idle channels 1 and 2
    svA = 4'b0001;
    @(negedge clk);
    chk("skip_pre_idx", 32'(gA), 0);
    svA = 4'b1001; sdA[0] = 8'h30; sdA[3] = 8'h33;
    @(negedge clk);
    chk("skip_first_idx", 32'(gA), 3);
    chk("skip_first_data", 32'(da.data), 32'h33);
    @(negedge clk);
    chk("skip_second_idx", 32'(gA), 0);
    chk("skip_second_data", 32'(da.data), 32'h30);
    svA = 4'b0000;
    @(negedge clk);
    sb_on = 1'b1;

    // random traffic on both instances, honouring the hold rule
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (!(svA[i] && !rA_s[i])) begin
          svA[i] = 1'($urandom_range(0, 1));
          sdA[i] = 8'($urandom);
        end
      end
      drA = ($urandom_range(0, 3) != 0);
      if (!(svB && !rB_s)) begin
        svB = 1'($urandom_range(0, 1));
        sdB = 1'($urandom);
      end
      drB = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    svA = 4'b0000; svB = 1'b0; drA = 1'b1; drB = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("b_drain", 32'(sbq.size()), 0);
    chk("b_seen", 32'(popped > 50), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
